// File: rtl/hwpe_stream_package.sv
// hwpe_stream_package: shared flag structs and state encodings for hwpe_stream blocks.
package hwpe_stream_package;
    typedef struct packed {
        logic       empty;
        logic       full;
        logic [7:0] push_pointer;
        logic [7:0] pop_pointer;
    } flags_fifo_t;
    typedef struct packed {
        logic busy;
        logic last;
    } flags_downsizer_t;
    typedef enum logic {IDLE, HOLD} downsizer_state_e;
endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// hwpe_stream_intf_stream: valid/ready stream with byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    modport source (output valid, output data, output strb, input ready);
    modport sink (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_downsizer_next_idx.sv
// hwpe_stream_downsizer_next_idx: beat skip encoder for HWPE_STREAM_DOWNSIZER_STRB_SKIP_EN;
// first live beat of the pushed word, next live beat after idx of the held word.
module hwpe_stream_downsizer_next_idx #(
    parameter int unsigned RATIO = 4,
    parameter int unsigned IW    = $clog2(RATIO)
) (
    input  logic [RATIO-1:0] push_mask,
    input  logic [RATIO-1:0] hold_mask,
    input  logic [IW-1:0]    idx,
    output logic [IW-1:0]    first,
    output logic [IW-1:0]    next,
    output logic             last,
    output logic             any
);
    // Descending scan so the lowest qualifying beat wins.
    always_comb begin
        first = '0;
        next  = idx;
        last  = 1'b1;
        for (int i = int'(RATIO) - 1; i >= 0; i--) begin
            first = push_mask[i] ? IW'(i) : first;
            if (hold_mask[i] && i > int'(idx)) begin
                next = IW'(i);
                last = 1'b0;
            end
        end
    end
    assign any = |push_mask;
endmodule

// File: rtl/hwpe_stream_downsizer.sv
// hwpe_stream_downsizer: splits wide stream words into narrow beats, LSB first.
// Define HWPE_STREAM_DOWNSIZER_STRB_SKIP_EN to skip beats whose strobes are all zero.
module hwpe_stream_downsizer
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH_IN  = 32,
    parameter int unsigned DATA_WIDTH_OUT = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    hwpe_stream_intf_stream.sink          push_i,
    hwpe_stream_intf_stream.source        pop_o,
    output flags_downsizer_t              flags_o
);
    localparam int unsigned RATIO = DATA_WIDTH_IN / DATA_WIDTH_OUT;
    localparam int unsigned IW    = $clog2(RATIO);
    localparam int unsigned SI    = DATA_WIDTH_IN / 8;
    localparam int unsigned SO    = DATA_WIDTH_OUT / 8;
    if (DATA_WIDTH_OUT % 8 != 0 || DATA_WIDTH_IN % DATA_WIDTH_OUT != 0 || RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
        $error("hwpe_stream_downsizer: DATA_WIDTH_IN/DATA_WIDTH_OUT must be a power of two >= 2");
    end
    downsizer_state_e    state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d, first_idx, next_idx;
    logic [DATA_WIDTH_IN-1:0] word_q, word_d;
    logic [SI-1:0]       strb_q, strb_d;
    logic                last_beat, push_any, push_hs, pop_hs;
`ifdef HWPE_STREAM_DOWNSIZER_STRB_SKIP_EN
    logic [RATIO-1:0] push_mask, hold_mask;
    for (genvar b = 0; b < int'(RATIO); b++) begin : g_mask
        assign push_mask[b] = |push_i.strb[b*SO +: SO];
        assign hold_mask[b] = |strb_q[b*SO +: SO];
    end
    hwpe_stream_downsizer_next_idx #(.RATIO(RATIO), .IW(IW)) i_next_idx (
        .push_mask (push_mask),
        .hold_mask (hold_mask),
        .idx       (idx_q),
        .first     (first_idx),
        .next      (next_idx),
        .last      (last_beat),
        .any       (push_any)
    );
`else
    assign first_idx = '0;
    assign push_any  = 1'b1;
    assign next_idx  = idx_q + 1'b1;
    assign last_beat = idx_q == IW'(RATIO - 1);
`endif
    assign pop_hs       = pop_o.valid & pop_o.ready;
    assign push_i.ready = ~clear_i & (state_q == IDLE | (pop_hs & last_beat));
    assign push_hs      = push_i.valid & push_i.ready;
    assign pop_o.valid  = state_q == HOLD;
    assign pop_o.data   = word_q[idx_q*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
    assign pop_o.strb   = strb_q[idx_q*SO +: SO];
    assign flags_o.busy = state_q == HOLD;
    assign flags_o.last = state_q == HOLD & last_beat;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        strb_d  = strb_q;
        if (clear_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (push_hs) begin
            word_d  = push_i.data;
            strb_d  = push_i.strb;
            idx_d   = first_idx;
            state_d = push_any ? HOLD : IDLE;
        end else if (pop_hs) begin
            state_d = last_beat ? IDLE : HOLD;
            idx_d   = last_beat ? idx_q : next_idx;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            strb_q  <= strb_d;
        end
    end
endmodule

// File: tb/tb_hwpe_stream_downsizer.sv
// tb_hwpe_stream_downsizer: directed checks of the 32->8 downsizer.
module tb_hwpe_stream_downsizer;
    import hwpe_stream_package::*;
    logic clk, rst, clear;
    flags_downsizer_t flags;
    int tests, failed;
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(8))  pop ();
    hwpe_stream_downsizer #(.DATA_WIDTH_IN(32), .DATA_WIDTH_OUT(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .push_i  (push),
        .pop_o   (pop),
        .flags_o (flags)
    );
    // {valid, data, strb, busy, last, push_ready}
    logic [12:0] obs;
    assign obs = {pop.valid, pop.data, pop.strb, flags.busy, flags.last, push.ready};
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [12:0] ev(input logic v, input logic [7:0] d, input logic s, input logic l, input logic pr);
        return {v, d, s, v, l, pr};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push_word(input logic [31:0] d, input logic [3:0] s);
        push.valid = 1'b1;
        push.data  = d;
        push.strb  = s;
    endtask
    task automatic test_reset();
        #3;
        tests++;
        if (obs !== ev(0, 8'h00, 0, 0, 1)) begin failed++; $display("FAIL reset_during got %h want %h", obs, ev(0, 8'h00, 0, 0, 1)); end
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        tests++;
        if (obs !== ev(0, 8'h00, 0, 0, 1)) begin failed++; $display("FAIL reset_after got %h want %h", obs, ev(0, 8'h00, 0, 0, 1)); end
    endtask
    task automatic test_single();
        logic [7:0] beats [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        logic [12:0] e;
        tick();
        pop.ready = 1'b1;
        push_word(32'hDDCCBBAA, 4'hF);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) push.valid = 1'b0;
            #1;
            e = ev(1, beats[i], 1, i == 3, i == 3);
            tests++;
            if (obs !== e) begin failed++; $display("FAIL single[%0d] got %h want %h", i, obs, e); end
        end
        tick();
        tests++;
        if ({obs[12], obs[0]} !== 2'b01) begin failed++; $display("FAIL single_idle got valid=%b ready=%b want 0 1", obs[12], obs[0]); end
    endtask
    task automatic test_back_to_back();
        logic [12:0] e;
        pop.ready = 1'b1;
        push_word(32'h44332211, 4'hF);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) push.data = 32'h88776655;
            if (i == 4) push.valid = 1'b0;
            #1;
            e = ev(1, 8'((i + 1) * 17), 1, i == 3 || i == 7, i == 3 || i == 7);
            tests++;
            if (obs !== e) begin failed++; $display("FAIL b2b[%0d] got %h want %h", i, obs, e); end
        end
        tick();
        tests++;
        if (obs[12] !== 1'b0) begin failed++; $display("FAIL b2b_idle got valid=%b want 0", obs[12]); end
    endtask
    task automatic test_stall();
        logic [12:0] e;
        pop.ready = 1'b1;
        push_word(32'hDDCCBBAA, 4'hF);
        tick();
        push.valid = 1'b0;
        #1;
        tests++;
        if (obs !== ev(1, 8'hAA, 1, 0, 0)) begin failed++; $display("FAIL stall_aa got %h want %h", obs, ev(1, 8'hAA, 1, 0, 0)); end
        tick();
        pop.ready = 1'b0;
        push_word(32'h12345678, 4'hF);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            if (k == 3) pop.ready = 1'b1;
            #1;
            tests++;
            if (obs !== ev(1, 8'hBB, 1, 0, 0)) begin failed++; $display("FAIL stall_bb[%0d] got %h want %h", k, obs, ev(1, 8'hBB, 1, 0, 0)); end
        end
        push.valid = 1'b0;
        tick();
        #1;
        tests++;
        if (obs !== ev(1, 8'hCC, 1, 0, 0)) begin failed++; $display("FAIL stall_cc got %h want %h", obs, ev(1, 8'hCC, 1, 0, 0)); end
        tick();
        #1;
        e = ev(1, 8'hDD, 1, 1, 1);
        tests++;
        if (obs !== e) begin failed++; $display("FAIL stall_dd got %h want %h", obs, e); end
        tick();
        tests++;
        if (obs[12] !== 1'b0) begin failed++; $display("FAIL stall_idle got valid=%b want 0", obs[12]); end
    endtask
    task automatic test_strb();
        logic [12:0] e;
        pop.ready = 1'b1;
        push_word(32'h44332211, 4'h5);
`ifdef HWPE_STREAM_DOWNSIZER_STRB_SKIP_EN
        for (int i = 0; i < 2; i++) begin
            tick();
            if (i == 0) push.valid = 1'b0;
            #1;
            e = ev(1, i == 0 ? 8'h11 : 8'h33, 1, i == 1, i == 1);
            tests++;
            if (obs !== e) begin failed++; $display("FAIL strb_skip[%0d] got %h want %h", i, obs, e); end
        end
        tick();
        push_word(32'h99999999, 4'h0);
        #1;
        tests++;
        if ({obs[12], obs[0]} !== 2'b01) begin failed++; $display("FAIL strb_zero_pre got valid=%b ready=%b want 0 1", obs[12], obs[0]); end
        tick();
        push.valid = 1'b0;
        #1;
        tests++;
        if ({obs[12], obs[0]} !== 2'b01) begin failed++; $display("FAIL strb_zero_post got valid=%b ready=%b want 0 1", obs[12], obs[0]); end
`else
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) push.valid = 1'b0;
            #1;
            e = ev(1, 8'((i + 1) * 17), i % 2 == 0, i == 3, i == 3);
            tests++;
            if (obs !== e) begin failed++; $display("FAIL strb_pass[%0d] got %h want %h", i, obs, e); end
        end
`endif
        tick();
        tests++;
        if (obs[12] !== 1'b0) begin failed++; $display("FAIL strb_idle got valid=%b want 0", obs[12]); end
    endtask
    task automatic test_clear();
        logic [12:0] e;
        pop.ready = 1'b1;
        push_word(32'hDDCCBBAA, 4'hF);
        tick();
        push.valid = 1'b0;
        #1;
        tests++;
        if (obs !== ev(1, 8'hAA, 1, 0, 0)) begin failed++; $display("FAIL clear_aa got %h want %h", obs, ev(1, 8'hAA, 1, 0, 0)); end
        clear = 1'b1;
        push_word(32'h04030201, 4'hF);
        #1;
        tests++;
        if (obs[0] !== 1'b0) begin failed++; $display("FAIL clear_push_ready got %b want 0", obs[0]); end
        tick();
        clear = 1'b0;
        #1;
        tests++;
        if ({obs[12], obs[0]} !== 2'b01) begin failed++; $display("FAIL clear_idle got valid=%b ready=%b want 0 1", obs[12], obs[0]); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) push.valid = 1'b0;
            #1;
            e = ev(1, 8'(i + 1), 1, i == 3, i == 3);
            tests++;
            if (obs !== e) begin failed++; $display("FAIL clear_next[%0d] got %h want %h", i, obs, e); end
        end
        tick();
    endtask
    task automatic test_reset_mid();
        pop.ready = 1'b1;
        push_word(32'hDDCCBBAA, 4'hF);
        tick();
        push.valid = 1'b0;
        tick();
        #1;
        tests++;
        if (obs !== ev(1, 8'hBB, 1, 0, 0)) begin failed++; $display("FAIL rstmid_bb got %h want %h", obs, ev(1, 8'hBB, 1, 0, 0)); end
        rst = 1'b1;
        #1;
        tests++;
        if (obs !== ev(0, 8'h00, 0, 0, 1)) begin failed++; $display("FAIL rstmid_async got %h want %h", obs, ev(0, 8'h00, 0, 0, 1)); end
        @(posedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (obs !== ev(0, 8'h00, 0, 0, 1)) begin failed++; $display("FAIL rstmid_idle[%0d] got %h want %h", k, obs, ev(0, 8'h00, 0, 0, 1)); end
        end
        push_word(32'h04030201, 4'hF);
        tick();
        push.valid = 1'b0;
        #1;
        tests++;
        if (obs !== ev(1, 8'h01, 1, 0, 0)) begin failed++; $display("FAIL rstmid_new got %h want %h", obs, ev(1, 8'h01, 1, 0, 0)); end
        for (int k = 0; k < 4; k++) tick();
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        tests = 0;
        failed = 0;
        rst = 1'b1;
        clear = 1'b0;
        push.valid = 1'b0;
        push.data = '0;
        push.strb = '0;
        pop.ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_strb();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/hwpe_stream_downsizer.md
HWPE_STREAM_DOWNSIZER -- requirements
Module: hwpe_stream_downsizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH_IN, default 32: push word width in bits.
REQ-002 SHALL have parameter DATA_WIDTH_OUT, default 8: pop beat width in bits; RATIO = DATA_WIDTH_IN/DATA_WIDTH_OUT SHALL be a power of two >= 2, elaboration error otherwise.
REQ-003 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clear_i  input  1  synchronous clear, active-high.
REQ-006 SHALL have port push_i  hwpe_stream_intf_stream.sink  DATA_WIDTH_IN  wide input stream (valid/ready/data/strb), fed by an upstream hwpe_stream_fifo pop port.
REQ-007 SHALL have port pop_o  hwpe_stream_intf_stream.source  DATA_WIDTH_OUT  narrow output stream.
REQ-008 SHALL have port flags_o  output  flags_downsizer_t  {busy, last}: word held, current beat is final beat of word.

Function
REQ-009 SHALL implement two states: IDLE (no word held) and HOLD (word held in word_q/strb_q, beat index idx_q of log2(RATIO) bits).
REQ-010 SHALL drive push_i.ready = (state==IDLE) or (pop handshake on last beat this cycle); no bubble between consecutive words.
REQ-011 SHALL, on push handshake, register data and strb, set idx_q to first emitted beat, enter HOLD; first pop beat valid exactly one cycle after push handshake.
REQ-012 SHALL drive pop_o.data = word_q[idx_q*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] and pop_o.strb the matching strb slice; beat order least-significant first.
REQ-013 SHALL assert pop_o.valid iff state==HOLD, from registers only; no combinational path pop_o.ready -> pop_o.valid, data or strb.
REQ-014 SHALL hold pop_o.data/strb/valid stable while pop_o.valid=1 and pop_o.ready=0.
REQ-015 SHALL, on pop handshake of a non-last beat, advance idx_q to next emitted beat; on last beat, go to IDLE unless a push handshake occurs the same cycle (then reload, stay HOLD).
REQ-016 SHALL sustain one pop beat per cycle under continuous pop_o.ready=1 and push_i.valid=1.
REQ-017 SHALL give clear_i priority over all handshakes: next state IDLE, idx_q=0, no push accepted in a clear cycle (push_i.ready=0 while clear_i=1).
REQ-018 SHALL drive flags_o.busy = (state==HOLD) and flags_o.last = busy and current beat is last.

Reset
REQ-019 SHALL, while rst_i=1, asynchronously force state=IDLE, idx_q=0, word_q=0, strb_q=0; hence pop_o.valid=0, pop_o.data=0, pop_o.strb=0, push_i.ready=1 after release, flags_o=0.
REQ-020 SHALL discard any partially emitted word on reset mid-operation; first beat after release comes from a new push.

Configuration
REQ-021 SHALL support macro HWPE_STREAM_DOWNSIZER_STRB_SKIP_EN.
REQ-022 With macro defined: beats whose strb slice is all-zero SHALL be skipped (first/next/last computed by priority encode over strb_q); a pushed word with strb all-zero SHALL be consumed with no pop beats and state stays/returns IDLE.
REQ-023 Without macro: all RATIO beats SHALL be emitted in order regardless of strb; strb slice passed through unchanged.

Structure
REQ-024 SHALL place typedef flags_downsizer_t in hwpe_stream_package alongside flags_fifo_t.
REQ-025 SHALL implement skip logic in sub-module hwpe_stream_downsizer_next_idx (combinational: strb, idx -> next idx, last, any); instantiated only under the macro.

Verification (32->8)
REQ-026 Push 0xDDCCBBAA strb 0xF, pop_ready=1 -> pop beats 0xAA,0xBB,0xCC,0xDD on cycles 1..4 after push; flags_o.last=1 on cycle 4 only.
REQ-027 Two back-to-back words 0x44332211, 0x88776655, pop_ready=1 -> 8 consecutive beats 0x11..0x88, no bubble; second push accepted in cycle of beat 0x44.
REQ-028 pop_ready=0 for 3 cycles while beat 0xBB valid -> 0xBB, strb 1, valid=1 held stable; push_ready=0 throughout.
REQ-029 Push 0x44332211 strb 0x5 -> with macro: beats 0x11, 0x33 only; without macro: 4 beats, strb 1,0,1,0. Strb 0x0 with macro -> no beats, push_ready stays 1.
REQ-030 clear_i=1 after beat 0xAA -> pop_valid=0 next cycle; next word 0x04030201 emits from 0x01.
REQ-031 rst_i asserted mid-word asynchronously between clock edges -> pop_valid=0 immediately, before next edge; after release idle until new push.
